// File: rtl/hpdmc_datactl.sv
// SDRAM data-phase controller: tracks burst, turnaround and write-recovery timing
// and drives PHY data direction and read-capture enables.
module hpdmc_datactl (
   input  logic       sys_clk,
   input  logic       sdram_rst,
   input  logic       tim_cas,
   input  logic [1:0] tim_wr,
   input  logic       read,
   input  logic       write,
   input  logic [3:0] concerned_bank,
   output logic       read_safe,
   output logic       write_safe,
   output logic [3:0] precharge_safe,
   output logic       direction,
   output logic       direction_r,
   output logic       read_capture
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned NB    = 4;
   localparam int unsigned RC_W  = 4;

   logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
   logic [NB-1:0][CNT_W-1:0] pc_cnt_q, pc_cnt_d;
   logic                     wr_pend_q, wr_pend_d;
   logic                     dir_q, dir_d;
   logic                     dir_r_q, dir_r_d;
   logic [RC_W-1:0]          rc_q, rc_d;
   logic                     cap_q, cap_d;

   logic [CNT_W-1:0]         rd_load, wr_load, pc_load;
   logic                     cmd;

   function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
      return (v != '0) ? v - CNT_W'(1) : v;
   endfunction

   function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Counter loads never shorten a pending window; a load overrides the decrement.
   always_comb begin
      cmd      = read | write;
      rd_load  = write ? CNT_W'(4) : CNT_W'(1);
      wr_load  = read ? (tim_cas ? CNT_W'(5) : CNT_W'(4)) : CNT_W'(1);
      pc_load  = write ? (CNT_W'(3) + CNT_W'(tim_wr)) : CNT_W'(1);

      rd_cnt_d = cmd ? umax(rd_cnt_q, rd_load) : dec(rd_cnt_q);
      wr_cnt_d = cmd ? umax(wr_cnt_q, wr_load) : dec(wr_cnt_q);
      for (int b = 0; b < NB; b++) begin
         pc_cnt_d[b] = (cmd && concerned_bank[b]) ? umax(pc_cnt_q[b], pc_load)
                                                  : dec(pc_cnt_q[b]);
      end
   end

   // Data path: two write-data cycles, read capture placed at CL+1 and CL+2.
   always_comb begin
      wr_pend_d = write;
      dir_d     = write | wr_pend_q;
      dir_r_d   = dir_q;
      rc_d      = rc_q >> 1;
      if (read) begin
         rc_d = rc_d | (tim_cas ? RC_W'(4'b1100) : RC_W'(4'b0110));
      end
      cap_d     = rc_q[0];
   end

   always_ff @(posedge sys_clk) begin
      if (sdram_rst) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         pc_cnt_q  <= '0;
         wr_pend_q <= 1'b0;
         dir_q     <= 1'b0;
         dir_r_q   <= 1'b0;
         rc_q      <= '0;
         cap_q     <= 1'b0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         pc_cnt_q  <= pc_cnt_d;
         wr_pend_q <= wr_pend_d;
         dir_q     <= dir_d;
         dir_r_q   <= dir_r_d;
         rc_q      <= rc_d;
         cap_q     <= cap_d;
      end
   end

   always_comb begin
      read_safe  = (rd_cnt_q == '0);
      write_safe = (wr_cnt_q == '0);
      for (int b = 0; b < NB; b++) begin
         precharge_safe[b] = (pc_cnt_q[b] == '0);
      end
   end

   assign direction    = dir_q;
   assign direction_r  = dir_r_q;
   assign read_capture = cap_q;

endmodule

// File: tb/tb_hpdmc_datactl.sv
// Directed bench for hpdmc_datactl: command pulses against hand-derived
// per-cycle output expectations.
module tb_hpdmc_datactl;

   logic       sys_clk = 1'b0;
   logic       sdram_rst;
   logic       tim_cas;
   logic [1:0] tim_wr;
   logic       read;
   logic       write;
   logic [3:0] concerned_bank;
   logic       read_safe;
   logic       write_safe;
   logic [3:0] precharge_safe;
   logic       direction;
   logic       direction_r;
   logic       read_capture;

   int errors = 0;
   int checks = 0;

   hpdmc_datactl dut (
      .sys_clk        (sys_clk),
      .sdram_rst      (sdram_rst),
      .tim_cas        (tim_cas),
      .tim_wr         (tim_wr),
      .read           (read),
      .write          (write),
      .concerned_bank (concerned_bank),
      .read_safe      (read_safe),
      .write_safe     (write_safe),
      .precharge_safe (precharge_safe),
      .direction      (direction),
      .direction_r    (direction_r),
      .read_capture   (read_capture)
   );

   always #5 sys_clk = ~sys_clk;

   // Observed vector: {read_safe, write_safe, precharge_safe[3:0], direction, direction_r, read_capture}
   function automatic logic [8:0] obs();
      return {read_safe, write_safe, precharge_safe, direction, direction_r, read_capture};
   endfunction

   function automatic logic [8:0] mk(input logic rs, input logic ws, input logic [3:0] pc,
                                     input logic d, input logic dr, input logic rc);
      return {rs, ws, pc, d, dr, rc};
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle_inputs();
      read = 1'b0;
      write = 1'b0;
      concerned_bank = 4'b0000;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      sdram_rst = 1'b1;
      idle_inputs();
      tim_cas = 1'b0;
      tim_wr = 2'd0;
      tick(); tick();
      sdram_rst = 1'b0;
      e = mk(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, obs(), e);
         end
      end
   endtask

   task automatic test_read(input logic cas);
      logic [8:0] e;
      int         cl;
      cl = cas ? 3 : 2;
      tick();
      tim_cas = cas;
      read = 1'b1;
      concerned_bank = 4'b0010;
      for (int k = 1; k <= 8; k++) begin
         tick();
         idle_inputs();
         e = mk(k != 1, !(k <= cl + 2), {1'b1, 1'b1, k != 1, 1'b1}, 1'b0, 1'b0,
                (k == cl + 1) || (k == cl + 2));
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL read_cl%0d cyc=t+%0d got=%b exp=%b", cl, k, obs(), e);
         end
      end
   endtask

   task automatic test_write();
      logic [8:0] e;
      tick();
      tim_wr = 2'd2;
      write = 1'b1;
      concerned_bank = 4'b1000;
      for (int k = 1; k <= 8; k++) begin
         tick();
         idle_inputs();
         e = mk(!(k <= 4), k != 1, {!(k <= 5), 1'b1, 1'b1, 1'b1},
                k >= 1 && k <= 2, k >= 2 && k <= 3, 1'b0);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL write_twr2 cyc=t+%0d got=%b exp=%b", k, obs(), e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e;
      tick();
      tim_wr = 2'd0;
      write = 1'b1;
      concerned_bank = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         tick();
         idle_inputs();
         if (k == 2) begin
            write = 1'b1;
            concerned_bank = 4'b0001;
         end
         e = mk(!(k <= 6), !(k == 1 || k == 3), {1'b1, 1'b1, 1'b1, !(k <= 5)},
                k >= 1 && k <= 4, k >= 2 && k <= 5, 1'b0);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL back_to_back cyc=t+%0d got=%b exp=%b", k, obs(), e);
         end
      end
   endtask

   task automatic test_reset_mid(input logic is_write);
      logic [8:0] e;
      tick();
      tim_wr = 2'd3;
      tim_cas = 1'b0;
      read = !is_write;
      write = is_write;
      concerned_bank = 4'b0001;
      tick();
      idle_inputs();
      sdram_rst = 1'b1;
      if (is_write) e = mk(1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
      else          e = mk(1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL rst_mid_pre wr=%0b got=%b exp=%b", is_write, obs(), e);
      end
      e = mk(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         tick();
         sdram_rst = 1'b0;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL rst_mid wr=%0b cyc=t+%0d got=%b exp=%b", is_write, k, obs(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read(1'b0);
      test_read(1'b1);
      test_write();
      test_back_to_back();
      test_reset_mid(1'b1);
      test_reset_mid(1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
